// File: rtl/cond_branch_sequencer.sv
// rtl/cond_branch_sequencer.sv - PC sequencer with condition evaluation and return stack
//
// Accepts STEP/JUMP/CALL/RET ops over a valid/ready handshake, evaluates a 3-bit
// condition code against a signed operand and updates the PC and a return stack.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   instr_valid/ready      op handshake (ready only in IDLE)
//   op, condition          op code (STEP/JUMP/CALL/RET), condition code
//   value, target          signed operand tested by condition, branch/call destination
//   clear_err              leaves ERROR state, clears fault flags
//   pc                     current program counter
//   taken                  one-cycle pulse with the condition result of the last op
//   stack_ovf, stack_unf   sticky stack fault flags
//   sp                     return stack occupancy
module cond_branch_sequencer #(
    parameter int PC_W        = 8,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [1:0]                   op,
    input  logic [2:0]                   condition,
    input  logic [DATA_W-1:0]            value,
    input  logic [PC_W-1:0]              target,
    input  logic                         clear_err,
    output logic [PC_W-1:0]              pc,
    output logic                         taken,
    output logic                         stack_ovf,
    output logic                         stack_unf,
    output logic [$clog2(STACK_DEPTH):0] sp
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [2:0]        cond_q;
    logic [DATA_W-1:0] value_q;
    logic [PC_W-1:0]   target_q;

    logic [PC_W-1:0]   stack_mem [STACK_DEPTH];

    logic              base_true;
    logic              cond_true;
    logic              stack_full;
    logic              stack_empty;
    logic              push_en;
    logic              pop_en;
    logic              fault;
    logic [SP_W-1:0]   sp_m1;
    logic [PC_W-1:0]   pc_inc;

    assign instr_ready = (state == ST_IDLE);

    // Bits [1:0] select the base test, bit 2 inverts it (000 never / 100 always).
    always_comb begin
        base_true = 1'b0;
        case (cond_q[1:0])
            2'b00: base_true = 1'b0;
            2'b01: base_true = (value_q == '0);
            2'b10: base_true = value_q[DATA_W-1];
            2'b11: base_true = value_q[DATA_W-1] | (value_q == '0);
            default: base_true = 1'b0;
        endcase
    end

    assign cond_true   = base_true ^ cond_q[2];
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_m1       = sp - SP_W'(1);
    assign pc_inc      = pc + PC_W'(1);

    always_comb begin
        push_en = 1'b0;
        pop_en  = 1'b0;
        fault   = 1'b0;
        if (state == ST_EVAL && cond_true) begin
            if (op_q == OP_CALL) begin
                push_en = !stack_full;
                fault   = stack_full;
            end else if (op_q == OP_RET) begin
                pop_en  = !stack_empty;
                fault   = stack_empty;
            end
        end
    end

    // Contents need no reset: occupancy is tracked by sp alone.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_STEP;
            cond_q    <= '0;
            value_q   <= '0;
            target_q  <= '0;
            pc        <= '0;
            taken     <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            sp        <= '0;
        end else begin
            taken <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q     <= op;
                        cond_q   <= condition;
                        value_q  <= value;
                        target_q <= target;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // STEP never reports a taken condition; faults still do.
                    taken <= (op_q != OP_STEP) && cond_true;
                    state <= fault ? ST_ERROR : ST_IDLE;
                    case (op_q)
                        OP_STEP: pc <= pc_inc;
                        OP_JUMP: pc <= cond_true ? target_q : pc_inc;
                        OP_CALL: begin
                            if (!cond_true) begin
                                pc <= pc_inc;
                            end else if (push_en) begin
                                pc <= target_q;
                                sp <= sp + SP_W'(1);
                            end else begin
                                stack_ovf <= 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!cond_true) begin
                                pc <= pc_inc;
                            end else if (pop_en) begin
                                pc <= stack_mem[sp_m1[IDX_W-1:0]];
                                sp <= sp_m1;
                            end else begin
                                stack_unf <= 1'b1;
                            end
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                ST_ERROR: begin
                    if (clear_err) begin
                        stack_ovf <= 1'b0;
                        stack_unf <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_branch_sequencer.sv
// tb/tb_cond_branch_sequencer.sv - self-checking bench for cond_branch_sequencer
module tb_cond_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] op = 2'b00;
    logic [2:0] condition = 3'b000;
    logic [7:0] value = 8'h00;
    logic [7:0] target = 8'h00;
    logic       clear_err = 1'b0;
    logic [7:0] pc;
    logic       taken;
    logic       stack_ovf;
    logic       stack_unf;
    logic [2:0] sp;

    int errors = 0;
    int checks = 0;

    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;
    bit m_err;

    cond_branch_sequencer #(.PC_W(8), .DATA_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .condition(condition), .value(value), .target(target),
        .clear_err(clear_err), .pc(pc), .taken(taken), .stack_ovf(stack_ovf),
        .stack_unf(stack_unf), .sp(sp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_cond(input int c, input logic [7:0] v);
        byte sb;
        int  s;
        sb = v;
        s  = sb;
        case (c)
            0: return 1'b0;
            1: return s == 0;
            2: return s < 0;
            3: return s <= 0;
            4: return 1'b1;
            5: return s != 0;
            6: return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        m_err = 0;
    endtask

    task automatic check_state(input string tag, input int exp_taken);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_taken"}, taken, exp_taken);
        check({tag, "_sp"}, sp, m_stack.size());
        check({tag, "_ovf"}, stack_ovf, m_ovf);
        check({tag, "_unf"}, stack_unf, m_unf);
        check({tag, "_rdy"}, instr_ready, !m_err);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [2:0] c,
                         input logic [7:0] v, input logic [7:0] t);
        bit tk;
        @(negedge clk);
        check({tag, "_idle_rdy"}, instr_ready, 1);
        op = o; condition = c; value = v; target = t; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op = 2'($urandom); condition = 3'($urandom);
        value = 8'($urandom); target = 8'($urandom);
        check({tag, "_eval_rdy"}, instr_ready, 0);
        check({tag, "_eval_taken"}, taken, 0);

        tk = (o == 2'b00) ? 1'b0 : ref_cond(int'(c), v);
        case (o)
            2'b00: m_pc = (m_pc + 1) % 256;
            2'b01: m_pc = tk ? int'(t) : (m_pc + 1) % 256;
            2'b10: begin
                if (!tk) m_pc = (m_pc + 1) % 256;
                else if (m_stack.size() < 4) begin
                    m_stack.push_back((m_pc + 1) % 256);
                    m_pc = int'(t);
                end else begin
                    m_ovf = 1; m_err = 1;
                end
            end
            default: begin
                if (!tk) m_pc = (m_pc + 1) % 256;
                else if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_unf = 1; m_err = 1;
                end
            end
        endcase

        @(posedge clk);
        #1;
        check_state(tag, tk);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear_err = 1'b1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        instr_valid = 1'b0;
        m_ovf = 0; m_unf = 0; m_err = 0;
        check_state(tag, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state("rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] vals [5];
        logic [7:0] rv;
        int         pick;
        vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h7F; vals[3] = 8'h80; vals[4] = 8'hFF;

        // reset and STEP
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst0", 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) do_op("step", 2'b00, 3'b100, 8'h00, 8'h55);
        check("step3_pc", pc, 3);
        do_op("jff", 2'b01, 3'b100, 8'h00, 8'hFF);
        do_op("wrap", 2'b00, 3'b000, 8'h00, 8'h00);
        check("wrap_pc", pc, 0);

        // directed JUMP on v<0
        do_op("jneg", 2'b01, 3'b010, 8'h80, 8'h40);
        do_op("jpos", 2'b01, 3'b010, 8'h7F, 8'h40);

        // condition sweep
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 5; k++)
                do_op($sformatf("sw_c%0d_v%0d", c, k), 2'b01, 3'(c), vals[k], 8'($urandom));

        // CALL / RET
        do_op("j5", 2'b01, 3'b100, 8'h00, 8'h05);
        do_op("call", 2'b10, 3'b100, 8'h00, 8'h10);
        do_op("ret", 2'b11, 3'b100, 8'h00, 8'h00);
        check("ret_pc", pc, 6);
        do_op("retn", 2'b11, 3'b000, 8'h00, 8'h00);
        check("retn_pc", pc, 7);

        // overflow, clear, drain, underflow
        for (int i = 0; i < 5; i++) do_op("ovf", 2'b10, 3'b100, 8'h00, 8'(8'h20 + i));
        check("ovf_flag", stack_ovf, 1);
        do_clear("clr_ovf");
        check("clr_sp", sp, 4);
        for (int i = 0; i < 4; i++) do_op("drain", 2'b11, 3'b100, 8'h00, 8'h00);
        do_op("unf", 2'b11, 3'b100, 8'h00, 8'h00);
        check("unf_flag", stack_unf, 1);
        do_clear("clr_unf");

        // reset during EVAL
        do_op("jpre", 2'b01, 3'b100, 8'h00, 8'h33);
        @(negedge clk);
        op = 2'b01; condition = 3'b100; target = 8'h20; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_sp", sp, 0);
        check("mid_rst_taken", taken, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", instr_ready, 1);

        // randomized ops against the model
        for (int n = 0; n < 400; n++) begin
            if (m_err) do_clear("rclr");
            pick = $urandom_range(0, 3);
            rv = (pick == 0) ? vals[$urandom_range(0, 4)] : 8'($urandom);
            do_op("rnd", 2'($urandom), 3'($urandom), rv, 8'($urandom));
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
